// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller and the
// E-stage mult/div datapath.
package pipeline_hazard_ctrl_pkg;

  // Tuse: cycles after D until a source operand is consumed
  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles after entering E until the result exists
  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  // D-stage forward source selects
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_sel_t;

  // Default mult/div occupancy after issue from E
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  // A source stalls when a producer in E or M will not have its result ready
  // by the time the consumer needs it. W always has its result.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] wa_e,
    input logic [1:0] tnew_e,
    input logic [4:0] wa_m,
    input logic [1:0] tnew_m
  );
    logic hit;
    hit = 1'b0;
    if (src != 5'd0 && tuse != TUSE_NONE) begin
      if (src == wa_e && tnew_e > tuse) hit = 1'b1;
      if (src == wa_m && tnew_m > tuse) hit = 1'b1;
    end
    return hit;
  endfunction

  // Youngest matching producer decides; a not-yet-ready youngest match
  // yields RF because the stall covers that case.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] src,
    input logic [4:0] wa_e,
    input logic [1:0] tnew_e,
    input logic [4:0] wa_m,
    input logic [1:0] tnew_m,
    input logic [4:0] wa_w
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (src == wa_e) begin
        if (tnew_e == 2'd0) sel = FWD_E;
      end else if (src == wa_m) begin
        if (tnew_m == 2'd0) sel = FWD_M;
      end else if (src == wa_w) begin
        sel = FWD_W;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_busy_counter.sv
// Mult/div occupancy counter: loads on issue from E, counts down to idle.
module md_busy_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [CNT_W-1:0] count;

  // Load on an accepted start, otherwise count down while occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end else if (start) begin
      count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline. Keeps a shadow
// scoreboard of E/M/W destinations and Tnew, compares it with the D-stage
// Tuse requirements, and tracks mult/div occupancy.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wa_d,
  input  logic [1:0] tnew_d,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  output logic       stall_pc,
  output logic       stall_d,
  output logic       flush_e,
  output logic [1:0] fwd_rs_d,
  output logic [1:0] fwd_rt_d,
  output logic       md_busy
);

  logic [4:0] wa_e, wa_m, wa_w;
  logic [1:0] tnew_e, tnew_m;
  logic       hazard_rs, hazard_rt, md_stall, stall, busy;
  fwd_sel_t   fwd_rs, fwd_rt;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_e),
    .is_div (md_is_div_e),
    .busy   (busy)
  );

  // Shadow scoreboard: advances with the pipeline, bubble into E on stall
  always_ff @(posedge clk) begin
    if (reset) begin
      wa_e   <= '0;
      tnew_e <= '0;
      wa_m   <= '0;
      tnew_m <= '0;
      wa_w   <= '0;
    end else begin
      wa_e   <= stall ? '0 : wa_d;
      tnew_e <= stall ? '0 : tnew_d;
      wa_m   <= wa_e;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      wa_w   <= wa_m;
    end
  end

  // Hazard detection and forward selection against the scoreboard
  always_comb begin
    hazard_rs = src_hazard(rs_d, tuse_rs_d, wa_e, tnew_e, wa_m, tnew_m);
    hazard_rt = src_hazard(rt_d, tuse_rt_d, wa_e, tnew_e, wa_m, tnew_m);
    md_stall  = md_use_d & (busy | md_start_e);
    stall     = hazard_rs | hazard_rt | md_stall;
    fwd_rs    = fwd_select(rs_d, wa_e, tnew_e, wa_m, tnew_m, wa_w);
    fwd_rt    = fwd_select(rt_d, wa_e, tnew_e, wa_m, tnew_m, wa_w);
  end

  // Output drive, all forced low while reset is held
  always_comb begin
    stall_pc = 1'b0;
    stall_d  = 1'b0;
    flush_e  = 1'b0;
    fwd_rs_d = '0;
    fwd_rt_d = '0;
    md_busy  = 1'b0;
    if (!reset) begin
      stall_pc = stall;
      stall_d  = stall;
      flush_e  = stall;
      fwd_rs_d = fwd_rs;
      fwd_rt_d = fwd_rt;
      md_busy  = busy;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, wa_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       md_use_d, md_start_e, md_is_div_e;
  logic       stall_pc, stall_d, flush_e, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rs_d        (rs_d),
    .rt_d        (rt_d),
    .tuse_rs_d   (tuse_rs_d),
    .tuse_rt_d   (tuse_rt_d),
    .wa_d        (wa_d),
    .tnew_d      (tnew_d),
    .md_use_d    (md_use_d),
    .md_start_e  (md_start_e),
    .md_is_div_e (md_is_div_e),
    .stall_pc    (stall_pc),
    .stall_d     (stall_d),
    .flush_e     (flush_e),
    .fwd_rs_d    (fwd_rs_d),
    .fwd_rt_d    (fwd_rt_d),
    .md_busy     (md_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: instructions in E (0), M (1), W (2), each with its destination and
  // the Tnew it had when it entered E; mult/div busy as a cycle window.
  int m_wa[3];
  int m_tn[3];
  int busy_end = 0;

  function automatic int eff_tnew(input int k);
    int t;
    if (k == 2) return 0;
    t = m_tn[k] - k;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int model_hazard(input int src, input int tuse);
    if (src == 0 || tuse == 3) return 0;
    for (int k = 0; k < 2; k++)
      if (m_wa[k] == src && eff_tnew(k) > tuse) return 1;
    return 0;
  endfunction

  function automatic int model_fwd(input int src);
    if (src == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (m_wa[k] == src) return (eff_tnew(k) == 0) ? k + 1 : 0;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return #1 later.
  // Literal expectations of -1 are skipped.
  task automatic step(input int l_stall, input int l_fwd, input int l_busy);
    int busy_now, st, e_st, e_frs, e_frt, e_busy;
    @(negedge clk);
    busy_now = (cyc < busy_end) ? 1 : 0;
    st = (model_hazard(rs_d, tuse_rs_d) | model_hazard(rt_d, tuse_rt_d) |
          (md_use_d & (busy_now | md_start_e))) ? 1 : 0;
    e_st   = reset ? 0 : st;
    e_frs  = reset ? 0 : model_fwd(rs_d);
    e_frt  = reset ? 0 : model_fwd(rt_d);
    e_busy = reset ? 0 : busy_now;
    chk("stall_pc", stall_pc, e_st);
    chk("stall_d",  stall_d,  e_st);
    chk("flush_e",  flush_e,  e_st);
    chk("fwd_rs_d", fwd_rs_d, e_frs);
    chk("fwd_rt_d", fwd_rt_d, e_frt);
    chk("md_busy",  md_busy,  e_busy);
    if (l_stall >= 0) chk("lit_stall", stall_pc, l_stall);
    if (l_fwd >= 0)   chk("lit_fwd_rs", fwd_rs_d, l_fwd);
    if (l_busy >= 0)  chk("lit_busy", md_busy, l_busy);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        m_wa[k] = 0;
        m_tn[k] = 0;
      end
      busy_end = 0;
    end else begin
      m_wa[2] = m_wa[1]; m_tn[2] = m_tn[1];
      m_wa[1] = m_wa[0]; m_tn[1] = m_tn[0];
      m_wa[0] = st ? 0 : wa_d;
      m_tn[0] = st ? 0 : tnew_d;
      if (!busy_now && md_start_e)
        busy_end = cyc + 1 + (md_is_div_e ? DIV_N : MULT_N);
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    rs_d = 0; rt_d = 0; tuse_rs_d = 3; tuse_rt_d = 3;
    wa_d = 0; tnew_d = 0;
    md_use_d = 0; md_start_e = 0; md_is_div_e = 0;
  endtask

  task automatic set_d(input int rs, input int tuse, input int wa, input int tn);
    rs_d = 5'(rs); tuse_rs_d = 2'(tuse); wa_d = 5'(wa); tnew_d = 2'(tn);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_wa[k] = 0;
      m_tn[k] = 0;
    end
    idle();
    reset = 1;
    md_use_d = 1; md_start_e = 1;
    rs_d = 5; wa_d = 5; tnew_d = 2;
    step(-1, -1, -1);
    step(0, 0, 0);
    idle();
    reset = 0;
    step(0, 0, 0);

    // Load-use: lw $8 then add using $8 in E
    set_d(0, 3, 8, 2);  step(0, 0, -1);
    set_d(8, 1, 9, 1);  step(1, 0, -1);
    step(0, -1, -1);
    set_d(8, 0, 0, 0);  step(0, 3, -1);
    idle(); step(-1, -1, -1); step(-1, -1, -1);

    // ALU result feeding a branch in D
    set_d(0, 3, 9, 1);  step(0, -1, -1);
    set_d(9, 0, 0, 0);  step(1, 0, -1);
    step(0, 2, -1);
    idle(); step(-1, -1, -1); step(-1, -1, -1);

    // jal then use of $31
    set_d(0, 3, 31, 0); step(0, -1, -1);
    set_d(31, 0, 0, 0); step(0, 1, -1);
    idle(); step(-1, -1, -1); step(-1, -1, -1);

    // $0 is never a hazard nor forwarded
    set_d(0, 3, 0, 2);  step(0, 0, -1);
    set_d(0, 0, 0, 0);  step(0, 0, -1);
    idle(); step(-1, -1, -1); step(-1, -1, -1);

    // div with mflo waiting in D
    md_use_d = 1; md_start_e = 1; md_is_div_e = 1;
    step(1, -1, 0);
    md_start_e = 0;
    for (int i = 0; i < DIV_N; i++) step(1, -1, 1);
    step(0, -1, 0);
    idle(); step(-1, -1, -1);

    // mult with mflo waiting in D
    md_use_d = 1; md_start_e = 1; md_is_div_e = 0;
    step(1, -1, 0);
    md_start_e = 0;
    for (int i = 0; i < MULT_N; i++) step(1, -1, 1);
    step(0, -1, 0);
    idle(); step(-1, -1, -1);

    // Reset in the middle of a div
    md_start_e = 1; md_is_div_e = 1;
    step(0, -1, 0);
    md_start_e = 0;
    for (int i = 0; i < 4; i++) step(0, -1, 1);
    md_use_d = 1; reset = 1;
    step(0, 0, 0);
    reset = 0;
    step(0, -1, 0);
    step(0, -1, 0);
    idle(); step(-1, -1, -1);

    // Randomized traffic on a small register set to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      rs_d        = 5'($urandom_range(0, 3));
      rt_d        = 5'($urandom_range(0, 3));
      tuse_rs_d   = 2'($urandom_range(0, 3));
      tuse_rt_d   = 2'($urandom_range(0, 3));
      wa_d        = 5'($urandom_range(0, 3));
      tnew_d      = 2'($urandom_range(0, 2));
      md_use_d    = ($urandom_range(0, 3) == 0);
      md_start_e  = ($urandom_range(0, 9) == 0);
      md_is_div_e = ($urandom_range(0, 1) == 1);
      reset       = ($urandom_range(0, 149) == 0);
      step(-1, -1, -1);
    end
    reset = 0;
    idle();
    step(-1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
